// File: rtl/maze_packet_rx.sv
`timescale 1ns/1ps
// maze_packet_rx
// Receives 3-wire serial maze update frames (SCLK/SDATA/SEN) from the robot
// microcontroller, assembles DATA_W-bit packets MSB-first, validates the
// fields, and strobes good packets to the grid-memory/VGA stage.
//
// Build option: define MAZE_RX_PARITY_EN to expect one extra trailing even
// parity bit per frame. The parity bit is checked but not stored.
//
// Ports:
//   CLOCK      system clock (25 MHz)
//   RESET      synchronous active-low reset
//   SCLK       serial clock, asynchronous; data sampled on rising edge
//   SDATA      serial data, MSB first
//   SEN        frame enable, high for the duration of a frame
//   PKT_VALID  one-cycle strobe for a good packet
//   PKT_DATA   last good packet, held between strobes
//   PKT_X      PKT_DATA[15:14]
//   PKT_Y      PKT_DATA[13:11]
//   PKT_TYPE   PKT_DATA[10:8]
//   PKT_WALLS  PKT_DATA[7:4] (N/E/S/W)
//   ERR_CNT    saturating count of rejected frames
//   BUSY       high when the FSM is not idle
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a synchronized SEN rising edge
// SHIFT    | collecting frame bits on SCLK rising edges
// WAIT_END | all bits received, waiting for SEN to fall
// DRAIN    | frame aborted, ignoring SCLK until SEN is low

module maze_packet_rx #(
  parameter int DATA_W         = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int GRID_W         = 4,
  parameter int GRID_H         = 5,
  parameter int NUM_TYPES      = 7
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              SCLK,
  input  logic              SDATA,
  input  logic              SEN,
  output logic              PKT_VALID,
  output logic [DATA_W-1:0] PKT_DATA,
  output logic [1:0]        PKT_X,
  output logic [2:0]        PKT_Y,
  output logic [2:0]        PKT_TYPE,
  output logic [3:0]        PKT_WALLS,
  output logic [7:0]        ERR_CNT,
  output logic              BUSY
);

`ifdef MAZE_RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END, DRAIN} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, sen_sync;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   sclk_hist, sen_hist;
  logic                   sclk_s, sdata_s, sen_s, sync_ready;
  logic                   sclk_rise, sen_rise, sen_fall;

  state_t             state_q, state_nxt;
  logic [FRAME_W-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic               valid_pend;

  logic               shift_en, frame_clr, timer_reload, err_inc, pkt_load;
  logic               timeout, field_ok, parity_ok, frame_ok;
  logic [DATA_W-1:0]  frame_data;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      sen_sync   <= '0;
      flush_q    <= '0;
      sclk_hist  <= 1'b0;
      sen_hist   <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
      sen_sync   <= {sen_sync[SYNC_STAGES-2:0], SEN};
      flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      sclk_hist  <= sclk_s;
      sen_hist   <= sen_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign sen_s   = sen_sync[SYNC_STAGES-1];

  // The synchronizers restart from 0 after reset, so a SEN already high would
  // look like a fresh rising edge. Edges are only trusted once the chain and
  // the history flop have been refilled from the pins.
  assign sync_ready = flush_q[SYNC_STAGES];
  assign sclk_rise  = sync_ready & sclk_s & ~sclk_hist;
  assign sen_rise   = sync_ready & sen_s & ~sen_hist;
  assign sen_fall   = sync_ready & ~sen_s & sen_hist;

  // Field check looks at the word including a bit shifted this same cycle,
  // so a SEN fall coinciding with the last SCLK edge is still judged at once.
  assign shift_nxt  = shift_en ? {shift_q[FRAME_W-2:0], sdata_s} : shift_q;
  assign frame_data = shift_nxt[FRAME_W-1 -: DATA_W];
  assign field_ok   = (int'(frame_data[DATA_W-1 -: 2]) < GRID_W) &&
                      (int'(frame_data[DATA_W-3 -: 3]) < GRID_H) &&
                      (int'(frame_data[DATA_W-6 -: 3]) < NUM_TYPES);
`ifdef MAZE_RX_PARITY_EN
  assign parity_ok  = ~^shift_nxt;
`else
  assign parity_ok  = 1'b1;
`endif
  assign frame_ok   = field_ok & parity_ok;
  assign timeout    = (timer_q == '0);

  always_comb begin
    state_nxt    = state_q;
    shift_en     = 1'b0;
    frame_clr    = 1'b0;
    timer_reload = 1'b0;
    err_inc      = 1'b0;
    pkt_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sen_rise) begin
          frame_clr = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_en     = 1'b1;
          timer_reload = 1'b1;
          if (cnt_q == LAST_CNT) begin
            if (sen_fall) begin
              state_nxt = IDLE;
              pkt_load  = frame_ok;
              err_inc   = ~frame_ok;
            end else begin
              state_nxt = WAIT_END;
            end
          end else if (sen_fall) begin
            err_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (sen_fall) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          err_inc   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      WAIT_END: begin
        if (sclk_rise) begin
          err_inc   = 1'b1;
          state_nxt = DRAIN;
        end else if (sen_fall) begin
          state_nxt = IDLE;
          pkt_load  = frame_ok;
          err_inc   = ~frame_ok;
        end else if (timeout) begin
          err_inc   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!sen_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      valid_pend <= 1'b0;
      PKT_VALID  <= 1'b0;
      PKT_DATA   <= '0;
      ERR_CNT    <= '0;
    end else begin
      state_q <= state_nxt;
      shift_q <= frame_clr ? '0 : shift_nxt;
      if (frame_clr)
        cnt_q <= '0;
      else if (shift_en)
        cnt_q <= cnt_q + CNT_W'(1);
      if (frame_clr || timer_reload)
        timer_q <= TMR_LOAD;
      else if (timer_q != '0)
        timer_q <= timer_q - TMR_W'(1);
      // Data is captured first, the strobe follows a cycle later.
      valid_pend <= pkt_load;
      PKT_VALID  <= valid_pend;
      if (pkt_load)
        PKT_DATA <= frame_data;
      if (err_inc && (ERR_CNT != 8'hFF))
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  assign PKT_X     = PKT_DATA[DATA_W-1 -: 2];
  assign PKT_Y     = PKT_DATA[DATA_W-3 -: 3];
  assign PKT_TYPE  = PKT_DATA[DATA_W-6 -: 3];
  assign PKT_WALLS = PKT_DATA[DATA_W-9 -: 4];
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_maze_packet_rx.sv
`timescale 1ns/1ps
module tb_maze_packet_rx;

  localparam int TMO = 300;
`ifdef MAZE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 16 + PAR;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  logic SCLK  = 1'b0;
  logic SDATA = 1'b0;
  logic SEN   = 1'b0;
  logic        PKT_VALID;
  logic [15:0] PKT_DATA;
  logic [1:0]  PKT_X;
  logic [2:0]  PKT_Y;
  logic [2:0]  PKT_TYPE;
  logic [3:0]  PKT_WALLS;
  logic [7:0]  ERR_CNT;
  logic        BUSY;

  always #5 CLOCK = ~CLOCK;

  maze_packet_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SCLK(SCLK), .SDATA(SDATA), .SEN(SEN),
    .PKT_VALID(PKT_VALID), .PKT_DATA(PKT_DATA), .PKT_X(PKT_X), .PKT_Y(PKT_Y),
    .PKT_TYPE(PKT_TYPE), .PKT_WALLS(PKT_WALLS), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  x;
    logic [2:0]  y;
    logic [2:0]  typ;
    logic [3:0]  walls;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_err  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected packet.
  always @(negedge CLOCK) begin
    if (RESET && PKT_VALID) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got strobe with PKT_DATA=%h, required no strobe", PKT_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pkt_data",  32'(PKT_DATA),  32'(mon_e.data));
        chk("pkt_x",     32'(PKT_X),     32'(mon_e.x));
        chk("pkt_y",     32'(PKT_Y),     32'(mon_e.y));
        chk("pkt_type",  32'(PKT_TYPE),  32'(mon_e.typ));
        chk("pkt_walls", 32'(PKT_WALLS), 32'(mon_e.walls));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic clk_bit(input logic b);
    SDATA = b;
    tick(6);
    SCLK = 1'b1;
    tick(6);
    SCLK = 1'b0;
  endtask

  // Sends the low n bits of w, MSB first.
  task automatic send_bits(input logic [17:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) clk_bit(w[i]);
  endtask

  function automatic logic [16:0] framed(input logic [15:0] d);
    if (PAR == 1) return {d, ^d};
    return {1'b0, d};
  endfunction

  task automatic push_exp(input logic [15:0] d, input logic [1:0] x, input logic [2:0] y,
                          input logic [2:0] t, input logic [3:0] w);
    exp_t e;
    e.data = d; e.x = x; e.y = y; e.typ = t; e.walls = w;
    exp_q.push_back(e);
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic full_frame(input logic [15:0] d, input bit good);
    SEN = 1'b1;
    tick(6);
    send_bits(18'(framed(d)), NB);
    if (!good) bump_err();
    SEN = 1'b0;
    tick(8);
  endtask

  // Counts CLOCK edges from the SEN pin falling until the strobe is seen.
  task automatic wait_valid(input string name);
    int  n = 0;
    bit  seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge CLOCK);
      #1;
      n++;
      if (PKT_VALID) seen = 1'b1;
    end
    chk(name, 32'(n), 32'd4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] fw;

    RESET = 1'b0;
    tick(5);
    chk("reset_valid", 32'(PKT_VALID), 32'd0);
    chk("reset_data",  32'(PKT_DATA),  32'd0);
    chk("reset_err",   32'(ERR_CNT),   32'd0);
    chk("reset_busy",  32'(BUSY),      32'd0);
    RESET = 1'b1;
    tick(4);

    // Good packet and its latency from the SEN pin falling.
    push_exp(16'h5350, 2'd1, 3'd2, 3'd3, 4'b0101);
    SEN = 1'b1;
    tick(6);
    send_bits(18'(framed(16'h5350)), NB);
    chk("busy_in_frame", 32'(BUSY), 32'd1);
    SEN = 1'b0;
    wait_valid("latency_good");
    tick(6);
    chk("err_after_good", 32'(ERR_CNT), 32'(exp_err));

    // Short frame.
    SEN = 1'b1;
    tick(6);
    send_bits(18'h0ABC, 12);
    SEN = 1'b0;
    bump_err();
    tick(8);
    chk("err_short",       32'(ERR_CNT),  32'(exp_err));
    chk("data_held_short", 32'(PKT_DATA), 32'h5350);
    chk("busy_after_short", 32'(BUSY),    32'd0);

    // Field checks: y out of range twice, then type 6 accepted.
    full_frame(16'h2800, 1'b0);
    chk("err_y5", 32'(ERR_CNT), 32'(exp_err));
    full_frame(16'h3800, 1'b0);
    chk("err_y7", 32'(ERR_CNT), 32'(exp_err));
    chk("data_held_field", 32'(PKT_DATA), 32'h5350);
    push_exp(16'h0600, 2'd0, 3'd0, 3'd6, 4'b0000);
    full_frame(16'h0600, 1'b1);
    chk("err_type6", 32'(ERR_CNT), 32'(exp_err));

    // SEN falls together with the last SCLK edge.
    push_exp(16'h1234, 2'd0, 3'd2, 3'd2, 4'b0011);
    fw = framed(16'h1234);
    SEN = 1'b1;
    tick(6);
    send_bits(18'(fw >> 1), NB - 1);
    SDATA = fw[0];
    tick(6);
    SCLK = 1'b1;
    SEN  = 1'b0;
    wait_valid("latency_simul");
    SCLK = 1'b0;
    tick(8);
    chk("err_simul", 32'(ERR_CNT), 32'(exp_err));

    // Timeout after 8 bits; BUSY held until SEN drops.
    SEN = 1'b1;
    tick(6);
    send_bits(18'(framed(16'hA5A5) >> (NB - 8)), 8);
    tick(TMO + 100);
    bump_err();
    chk("err_timeout",  32'(ERR_CNT), 32'(exp_err));
    chk("busy_drain",   32'(BUSY),    32'd1);
    SEN = 1'b0;
    tick(8);
    chk("busy_after_drain", 32'(BUSY), 32'd0);

    // Overrun: one bit too many.
    SEN = 1'b1;
    tick(6);
    send_bits({framed(16'h1234), 1'b0}, NB + 1);
    bump_err();
    SEN = 1'b0;
    tick(8);
    chk("err_overrun", 32'(ERR_CNT), 32'(exp_err));

    // Reset mid-frame; the rest of the frame must be ignored.
    SEN = 1'b1;
    tick(6);
    send_bits(18'(framed(16'h5350) >> (NB - 9)), 9);
    RESET = 1'b0;
    tick(3);
    RESET = 1'b1;
    exp_err = 0;
    send_bits(18'(framed(16'h5350)), NB - 9);
    SEN = 1'b0;
    tick(8);
    chk("err_after_reset",  32'(ERR_CNT),  32'd0);
    chk("data_after_reset", 32'(PKT_DATA), 32'd0);
    chk("busy_after_reset", 32'(BUSY),     32'd0);
    full_frame(16'hFFF0, 1'b0);
    chk("err_fff0", 32'(ERR_CNT), 32'(exp_err));

`ifdef MAZE_RX_PARITY_EN
    push_exp(16'h5350, 2'd1, 3'd2, 3'd3, 4'b0101);
    full_frame(16'h5350, 1'b1);
    chk("err_parity_good", 32'(ERR_CNT), 32'(exp_err));
    SEN = 1'b1;
    tick(6);
    send_bits({1'b0, 16'h5350, ~(^16'h5350)}, NB);
    bump_err();
    SEN = 1'b0;
    tick(8);
    chk("err_parity_bad", 32'(ERR_CNT), 32'(exp_err));
`endif

    // Saturation: empty frames are short-frame errors.
    for (int k = 0; k < 260; k++) begin
      SEN = 1'b1;
      tick(4);
      SEN = 1'b0;
      tick(5);
      bump_err();
    end
    tick(4);
    chk("err_saturate", 32'(ERR_CNT), 32'(exp_err));

    tick(10);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
